// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks.
//   rdr_state_e   : burst reader FSM states
//   RDR_BUF_DEPTH : entries in the reader's output skid buffer
package fifo_pkg;
  typedef enum logic [1:0] {RDR_IDLE, RDR_RUN, RDR_DONE} rdr_state_e;
  localparam int RDR_BUF_DEPTH = 2;
endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry stream buffer with registered occupancy.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i (ignored when full and not popping)
//   push_data_i  : entry to store
//   pop_i        : drop the head entry (ignored when empty)
//   occ_o        : registered occupancy, 0..2
//   valid_o      : occ_o != 0
//   data_o       : head entry (registered)
module stream_skid_buf2 #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       occ_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop_eff, push_eff;

  // A pop on an empty buffer is dropped; a push on a full buffer only
  // lands when the same cycle frees the head.
  assign pop_eff  = pop_i & (occ_q != 2'd0);
  assign push_eff = push_i & ((occ_q != 2'd2) | pop_eff);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    unique case ({push_eff, pop_eff})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = push_data_i;
        else               ent1_d = push_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // occupancy unchanged; head advances
        if (occ_q == 2'd1) begin
          ent0_d = push_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ_o   = occ_q;
  assign valid_o = (occ_q != 2'd0);
  assign data_o  = ent0_q;
endmodule

// File: rtl/fifo_burst_reader.sv
// Pops len_i words from a sync FIFO and replays them on a valid/ready
// stream, tagging the final word with m_last_o.
//   clk, rst           : clock, synchronous active-high reset
//   start_i, len_i     : burst request (sampled in IDLE only)
//   busy_o, done_o     : burst in flight / one-cycle completion pulse
//   fifo_rd_en_o       : FIFO pop strobe
//   fifo_rd_data_i     : FIFO head word (combinational read)
//   fifo_empty_i       : FIFO empty flag
//   m_valid_o/m_ready_i/m_data_o/m_last_o : output stream
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_rd_data_i,
  input  logic             fifo_empty_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o
);
  localparam logic [1:0] BUF_DEPTH = 2'(RDR_BUF_DEPTH);

  rdr_state_e       state_q, state_d;
  logic [LEN_W-1:0] rd_rem_q, rd_rem_d, out_rem_q, out_rem_d;
  logic [1:0]       occ;
  logic             pop, hs;
  logic [WIDTH:0]   buf_data;

  // Pop decision uses registered state only, so m_ready_i never reaches
  // the FIFO read strobe combinationally.
  assign pop = (state_q == RDR_RUN) & ~fifo_empty_i & (rd_rem_q != '0) & (occ < BUF_DEPTH);
  assign hs  = m_valid_o & m_ready_i;

  always_comb begin
    state_d   = state_q;
    rd_rem_d  = rd_rem_q;
    out_rem_d = out_rem_q;
    unique case (state_q)
      RDR_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            rd_rem_d  = len_i;
            out_rem_d = len_i;
            state_d   = RDR_RUN;
          end else begin
            state_d = RDR_DONE;
          end
        end
      end
      RDR_RUN: begin
        if (pop) rd_rem_d = rd_rem_q - LEN_W'(1);
        if (hs && out_rem_q != '0) out_rem_d = out_rem_q - LEN_W'(1);
        if (hs && out_rem_q == LEN_W'(1)) state_d = RDR_DONE;
      end
      RDR_DONE: state_d = RDR_IDLE;
      default:  state_d = RDR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RDR_IDLE;
      rd_rem_q  <= '0;
      out_rem_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_rem_q  <= rd_rem_d;
      out_rem_q <= out_rem_d;
    end
  end

  // Entry = {last tag, data}; the tag is fixed at pop time.
  stream_skid_buf2 #(.WIDTH(WIDTH + 1)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pop),
    .push_data_i ({(rd_rem_q == LEN_W'(1)), fifo_rd_data_i}),
    .pop_i       (hs),
    .occ_o       (occ),
    .valid_o     (m_valid_o),
    .data_o      (buf_data)
  );

  assign fifo_rd_en_o = pop;
  assign m_data_o     = buf_data[WIDTH-1:0];
  assign m_last_o     = buf_data[WIDTH];
  assign busy_o       = (state_q != RDR_IDLE);
  assign done_o       = (state_q == RDR_DONE);
endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic             busy_o, done_o, fifo_rd_en_o;
  logic [WIDTH-1:0] fifo_rd_data_i;
  logic             fifo_empty_i;
  logic             m_valid_o, m_ready_i, m_last_o;
  logic [WIDTH-1:0] m_data_o;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .len_i          (len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_empty_i   (fifo_empty_i),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_data_o       (m_data_o),
    .m_last_o       (m_last_o)
  );

  // Behavioural sync FIFO: written by the stimulus, popped by the DUT.
  logic [WIDTH-1:0] mem [64];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  logic             flush = 1'b0;

  assign fifo_empty_i   = (wr_ptr == rd_ptr);
  assign fifo_rd_data_i = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (flush)             rd_ptr <= wr_ptr;
    else if (fifo_rd_en_o) rd_ptr <= rd_ptr + 1;
  end

  // Scoreboard of {last, data} expected on the stream.
  logic [WIDTH:0] exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, pops = 0, beats = 0, valids = 0, dones = 0;
  int first_pop = -1, first_beat = -1, last_beat = -1, done_cyc = -1;

  task automatic fifo_write(input logic [WIDTH-1:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_beat(input logic [WIDTH-1:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic clear_stats();
    pops = 0; beats = 0; valids = 0; dones = 0;
    first_pop = -1; first_beat = -1; last_beat = -1; done_cyc = -1;
  endtask

  // One clock: observe what the coming edge will do, then advance.
  task automatic tick();
    logic [WIDTH:0] e;
    #1;
    cyc++;
    if (fifo_rd_en_o) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      checks++;
      if (fifo_empty_i) begin
        errors++;
        $display("FAIL pop_while_empty cyc=%0d rd_en=1 empty=1 required rd_en=0", cyc);
      end
    end
    if (m_valid_o) valids++;
    if (m_valid_o && m_ready_i) begin
      beats++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat data=%h last=%b required no beat", m_data_o, m_last_o);
      end else begin
        e = exp_q.pop_front();
        if ({m_last_o, m_data_o} !== e) begin
          errors++;
          $display("FAIL beat got last=%b data=%h required last=%b data=%h",
                   m_last_o, m_data_o, e[WIDTH], e[WIDTH-1:0]);
        end
      end
    end
    if (done_o) begin
      dones++;
      done_cyc = cyc;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (dones == 0) begin
      errors++;
      $display("FAIL done_timeout got no done_o in %0d cycles required done_o", budget);
    end
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle got done=%b busy=%b required 0 0", done_o, busy_o);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; len_i = '0; m_ready_i = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy_o, done_o, fifo_rd_en_o, m_valid_o, m_last_o} !== 5'b0 || m_data_o !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b rd=%b vld=%b last=%b data=%h required all 0",
               busy_o, done_o, fifo_rd_en_o, m_valid_o, m_last_o, m_data_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    clear_stats();
    fifo_write(8'h11); fifo_write(8'h22); fifo_write(8'h33); fifo_write(8'h44);
    expect_beat(8'h11, 0); expect_beat(8'h22, 0); expect_beat(8'h33, 0); expect_beat(8'h44, 1);
    m_ready_i = 1'b1; start_i = 1'b1; len_i = 8'd4;
    tick();
    start_i = 1'b0;
    wait_done(40);
    checks++;
    if (beats != 4 || pops != 4) begin
      errors++;
      $display("FAIL basic_counts got beats=%0d pops=%0d required 4 4", beats, pops);
    end
    checks++;
    if (first_beat != first_pop + 1) begin
      errors++;
      $display("FAIL basic_latency got beat@%0d pop@%0d required beat=pop+1", first_beat, first_pop);
    end
    checks++;
    if (last_beat - first_beat != 3 || done_cyc != last_beat + 1) begin
      errors++;
      $display("FAIL basic_timing got first=%0d last=%0d done=%0d required consecutive, done=last+1",
               first_beat, last_beat, done_cyc);
    end
    checks++;
    if (fifo_empty_i !== 1'b1) begin
      errors++;
      $display("FAIL basic_fifo_empty got empty=%b required 1", fifo_empty_i);
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    fifo_write(8'h51); fifo_write(8'h52); fifo_write(8'h53);
    expect_beat(8'h51, 0); expect_beat(8'h52, 0); expect_beat(8'h53, 1);
    m_ready_i = 1'b0; start_i = 1'b1; len_i = 8'd3;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    checks++;
    if (pops != 2 || fifo_rd_en_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got pops=%0d rd_en=%b required 2 0", pops, fifo_rd_en_o);
    end
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 8'h51 || m_last_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got vld=%b data=%h last=%b required 1 51 0", m_valid_o, m_data_o, m_last_o);
    end
    m_ready_i = 1'b1;
    wait_done(40);
    checks++;
    if (beats != 3 || pops != 3) begin
      errors++;
      $display("FAIL bp_counts got beats=%0d pops=%0d required 3 3", beats, pops);
    end
  endtask

  task automatic test_underflow();
    clear_stats();
    fifo_write(8'h77);
    expect_beat(8'h77, 0); expect_beat(8'hA0, 0); expect_beat(8'hB0, 1);
    m_ready_i = 1'b1; start_i = 1'b1; len_i = 8'd3;
    tick();
    start_i = 1'b0;
    repeat (8) tick();
    checks++;
    if (beats != 1 || busy_o !== 1'b1 || m_valid_o !== 1'b0 || dones != 0) begin
      errors++;
      $display("FAIL uf_stall got beats=%0d busy=%b vld=%b dones=%0d required 1 1 0 0",
               beats, busy_o, m_valid_o, dones);
    end
    fifo_write(8'hA0);
    tick();
    fifo_write(8'hB0);
    wait_done(40);
    checks++;
    if (beats != 3 || pops != 3) begin
      errors++;
      $display("FAIL uf_counts got beats=%0d pops=%0d required 3 3", beats, pops);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    clear_stats();
    m_ready_i = 1'b1; start_i = 1'b1; len_i = 8'd0;
    tick();
    start_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b required 1 1", done_o, busy_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || pops != 0 || valids != 0) begin
      errors++;
      $display("FAIL zero_after got done=%b busy=%b pops=%0d valids=%0d required 0 0 0 0",
               done_o, busy_o, pops, valids);
    end
    clear_stats();
    fifo_write(8'hC1); fifo_write(8'hC2); fifo_write(8'hC3);
    expect_beat(8'hC1, 0); expect_beat(8'hC2, 0); expect_beat(8'hC3, 1);
    start_i = 1'b1; len_i = 8'd3;
    tick();
    len_i = 8'd5;
    repeat (2) tick();
    start_i = 1'b0;
    wait_done(40);
    repeat (3) tick();
    checks++;
    if (beats != 3 || pops != 3 || busy_o !== 1'b0 || dones != 1) begin
      errors++;
      $display("FAIL ignored_start got beats=%0d pops=%0d busy=%b dones=%0d required 3 3 0 1",
               beats, pops, busy_o, dones);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    clear_stats();
    fifo_write(8'hD1); fifo_write(8'hD2);
    expect_beat(8'hD1, 0); expect_beat(8'hD2, 0);
    m_ready_i = 1'b1; start_i = 1'b1; len_i = 8'd5;
    tick();
    start_i = 1'b0;
    while (beats < 2 && n < 20) begin
      tick();
      n++;
    end
    repeat (2) tick();
    checks++;
    if (beats != 2 || pops != 2 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got beats=%0d pops=%0d busy=%b required 2 2 1", beats, pops, busy_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fifo_write(8'hE1); fifo_write(8'hE2); fifo_write(8'hE3);
    checks++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || dones != 0) begin
      errors++;
      $display("FAIL rst_abort got vld=%b busy=%b done=%b dones=%0d required 0 0 0 0",
               m_valid_o, busy_o, done_o, dones);
    end
    repeat (3) tick();
    checks++;
    if (wr_ptr - rd_ptr != 3 || pops != 2) begin
      errors++;
      $display("FAIL rst_fifo_kept got count=%0d pops=%0d required 3 2", wr_ptr - rd_ptr, pops);
    end
    // The surviving words form a clean new burst.
    expect_beat(8'hE1, 0); expect_beat(8'hE2, 0); expect_beat(8'hE3, 1);
    start_i = 1'b1; len_i = 8'd3;
    tick();
    start_i = 1'b0;
    wait_done(40);
    checks++;
    if (beats != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_followup got beats=%0d pending=%0d required 5 0", beats, exp_q.size());
    end
  endtask

  task automatic test_overrun();
    clear_stats();
    for (int i = 0; i < 6; i++) fifo_write(8'(8'hF0 + i));
    for (int i = 0; i < 4; i++) expect_beat(8'(8'hF0 + i), i == 3);
    m_ready_i = 1'b1; start_i = 1'b1; len_i = 8'd4;
    tick();
    start_i = 1'b0;
    wait_done(40);
    repeat (2) tick();
    checks++;
    if (pops != 4 || beats != 4 || wr_ptr - rd_ptr != 2) begin
      errors++;
      $display("FAIL overrun got pops=%0d beats=%0d left=%0d required 4 4 2",
               pops, beats, wr_ptr - rd_ptr);
    end
    do_flush();
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; len_i = '0; m_ready_i = 1'b1;
    @(negedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_zero_and_ignored_start();
    test_reset_mid_burst();
    test_overrun();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
